// File: rtl/wbu_commit_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wbu_commit_arbiter_pkg
// Description : Shared types and constants for the dual-way writeback unit.
// Revision    : 1.0 - initial release
// ============================================================================
package wbu_commit_arbiter_pkg;

    localparam int PID_W   = 2;
    localparam int WB_XLEN = 64;

    // Head pID shown on each port while its FIFO is empty
    localparam logic [PID_W-1:0] PID_WAY0_INIT = 2'b00;
    localparam logic [PID_W-1:0] PID_WAY1_INIT = 2'b01;

    typedef struct packed {
        logic               we;
        logic [4:0]         addr;
        logic [WB_XLEN-1:0] data;
        logic [PID_W-1:0]   pid;
    } wb_entry_t;

endpackage : wbu_commit_arbiter_pkg
`default_nettype wire

// File: rtl/wbu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wbu_result_fifo
// Description : Small result FIFO with head peek, full and empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module wbu_result_fifo
    import wbu_commit_arbiter_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wb_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  T     i_push_data,
    input  logic i_pop,
    output T     o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    T            r_mem [DEPTH];

    // Pointer update; the extra top bit separates full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (i_pop && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule : wbu_result_fifo
`default_nettype wire

// File: rtl/wbu_commit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wbu_commit_arbiter
// Description : Buffers results from two issue ways and commits them to the
//               dual-port register file in pID program order, up to two
//               per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wbu_commit_arbiter
    import wbu_commit_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             way0_valid_i,
    output logic             way0_ready_o,
    input  logic             way0_rdWriteEnable_i,
    input  logic [4:0]       way0_rdAddr_i,
    input  logic [XLEN-1:0]  way0_rdData_i,
    input  logic [PID_W-1:0] way0_pID_i,
    input  logic             way1_valid_i,
    output logic             way1_ready_o,
    input  logic             way1_rdWriteEnable_i,
    input  logic [4:0]       way1_rdAddr_i,
    input  logic [XLEN-1:0]  way1_rdData_i,
    input  logic [PID_W-1:0] way1_pID_i,
    output logic             way0_rdWriteEnable_o,
    output logic [4:0]       way0_rdAddr_o,
    output logic [XLEN-1:0]  way0_rdData_o,
    output logic [PID_W-1:0] way0_WBU_pID_o,
    input  logic             way0_ready_i,
    output logic             way1_rdWriteEnable_o,
    output logic [4:0]       way1_rdAddr_o,
    output logic [XLEN-1:0]  way1_rdData_o,
    output logic [PID_W-1:0] way1_WBU_pID_o,
    input  logic             way1_ready_i,
    output logic             pid_err_o
);

    typedef struct packed {
        logic             we;
        logic [4:0]       addr;
        logic [XLEN-1:0]  data;
        logic [PID_W-1:0] pid;
    } entry_t;

    logic [PID_W-1:0] r_next_pid;
    logic             r_pid_err;

    entry_t w_in0, w_in1, w_head0, w_head1;
    logic   w_full0, w_full1, w_empty0, w_empty1;
    logic   w_push0, w_push1, w_bad0, w_bad1;
    logic   w_commit0, w_commit1;
    logic   w_hit0, w_hit1, w_wr0, w_wr1, w_same_rd, w_old_is_way0;
    logic [PID_W-1:0] w_pid_next1;

    assign way0_ready_o = !w_full0;
    assign way1_ready_o = !w_full1;

    // Way0 only carries even pIDs, way1 only odd ones; anything else is dropped
    assign w_push0 = way0_valid_i && way0_ready_o && !way0_pID_i[0];
    assign w_push1 = way1_valid_i && way1_ready_o &&  way1_pID_i[0];
    assign w_bad0  = way0_valid_i && way0_ready_o &&  way0_pID_i[0];
    assign w_bad1  = way1_valid_i && way1_ready_o && !way1_pID_i[0];

    assign w_in0 = '{we: way0_rdWriteEnable_i, addr: way0_rdAddr_i,
                     data: way0_rdData_i, pid: way0_pID_i};
    assign w_in1 = '{we: way1_rdWriteEnable_i, addr: way1_rdAddr_i,
                     data: way1_rdData_i, pid: way1_pID_i};

    wbu_result_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo_way0 (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push0),
        .i_push_data (w_in0),
        .i_pop       (w_commit0),
        .o_head      (w_head0),
        .o_full      (w_full0),
        .o_empty     (w_empty0)
    );

    wbu_result_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo_way1 (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push1),
        .i_push_data (w_in1),
        .i_pop       (w_commit1),
        .o_head      (w_head1),
        .o_full      (w_full1),
        .o_empty     (w_empty1)
    );

    // Commit decision: the oldest slot (next_pid) must commit before its successor may
    always_comb begin
        w_old_is_way0 = !r_next_pid[0];
        w_pid_next1   = r_next_pid + 2'd1;
        w_hit0 = !w_empty0 && way0_ready_i &&
                 (w_head0.pid == (w_old_is_way0 ? r_next_pid : w_pid_next1));
        w_hit1 = !w_empty1 && way1_ready_i &&
                 (w_head1.pid == (w_old_is_way0 ? w_pid_next1 : r_next_pid));
        w_commit0 = w_old_is_way0 ? w_hit0 : (w_hit0 && w_hit1);
        w_commit1 = w_old_is_way0 ? (w_hit1 && w_hit0) : w_hit1;
        w_wr0 = w_commit0 && w_head0.we && (w_head0.addr != 5'd0);
        w_wr1 = w_commit1 && w_head1.we && (w_head1.addr != 5'd0);
        // When both write the same register the younger value must win
        w_same_rd = w_wr0 && w_wr1 && (w_head0.addr == w_head1.addr);
        way0_rdWriteEnable_o = w_wr0 && !(w_same_rd &&  w_old_is_way0);
        way1_rdWriteEnable_o = w_wr1 && !(w_same_rd && !w_old_is_way0);
    end

    // Head peek: regfile ready may depend on these but never on the strobes
    assign way0_rdAddr_o  = w_empty0 ? 5'd0 : w_head0.addr;
    assign way0_rdData_o  = w_empty0 ? '0   : w_head0.data;
    assign way0_WBU_pID_o = w_empty0 ? PID_WAY0_INIT : w_head0.pid;
    assign way1_rdAddr_o  = w_empty1 ? 5'd0 : w_head1.addr;
    assign way1_rdData_o  = w_empty1 ? '0   : w_head1.data;
    assign way1_WBU_pID_o = w_empty1 ? PID_WAY1_INIT : w_head1.pid;

    // Program-order pointer advances by the number of results retired this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_next_pid <= PID_WAY0_INIT;
        end else begin
            r_next_pid <= r_next_pid + PID_W'(w_commit0) + PID_W'(w_commit1);
        end
    end

    // Sticky error flag for any result arriving on the wrong way
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pid_err <= 1'b0;
        end else if (w_bad0 || w_bad1) begin
            r_pid_err <= 1'b1;
        end
    end

    assign pid_err_o = r_pid_err;

endmodule : wbu_commit_arbiter
`default_nettype wire

// File: tb/tb_wbu_commit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wbu_commit_arbiter
// Description : Scoreboard bench for the dual-way writeback unit, with a
//               queue-based program-order reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wbu_commit_arbiter;

    localparam int DEPTH = 2;
    localparam int XLEN  = 64;
    localparam int NPROG = 240;
    localparam int MAXCYC = 6000;

    logic            clk = 1'b0;
    logic            reset;
    logic            way0_valid_i, way0_rdWriteEnable_i, way0_ready_o;
    logic [4:0]      way0_rdAddr_i;
    logic [XLEN-1:0] way0_rdData_i;
    logic [1:0]      way0_pID_i;
    logic            way1_valid_i, way1_rdWriteEnable_i, way1_ready_o;
    logic [4:0]      way1_rdAddr_i;
    logic [XLEN-1:0] way1_rdData_i;
    logic [1:0]      way1_pID_i;
    logic            way0_rdWriteEnable_o, way1_rdWriteEnable_o;
    logic [4:0]      way0_rdAddr_o, way1_rdAddr_o;
    logic [XLEN-1:0] way0_rdData_o, way1_rdData_o;
    logic [1:0]      way0_WBU_pID_o, way1_WBU_pID_o;
    logic            way0_ready_i, way1_ready_i;
    logic            pid_err_o;

    always #5 clk = ~clk;

    wbu_commit_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk                  (clk),
        .reset                (reset),
        .way0_valid_i         (way0_valid_i),
        .way0_ready_o         (way0_ready_o),
        .way0_rdWriteEnable_i (way0_rdWriteEnable_i),
        .way0_rdAddr_i        (way0_rdAddr_i),
        .way0_rdData_i        (way0_rdData_i),
        .way0_pID_i           (way0_pID_i),
        .way1_valid_i         (way1_valid_i),
        .way1_ready_o         (way1_ready_o),
        .way1_rdWriteEnable_i (way1_rdWriteEnable_i),
        .way1_rdAddr_i        (way1_rdAddr_i),
        .way1_rdData_i        (way1_rdData_i),
        .way1_pID_i           (way1_pID_i),
        .way0_rdWriteEnable_o (way0_rdWriteEnable_o),
        .way0_rdAddr_o        (way0_rdAddr_o),
        .way0_rdData_o        (way0_rdData_o),
        .way0_WBU_pID_o       (way0_WBU_pID_o),
        .way0_ready_i         (way0_ready_i),
        .way1_rdWriteEnable_o (way1_rdWriteEnable_o),
        .way1_rdAddr_o        (way1_rdAddr_o),
        .way1_rdData_o        (way1_rdData_o),
        .way1_WBU_pID_o       (way1_WBU_pID_o),
        .way1_ready_i         (way1_ready_i),
        .pid_err_o            (pid_err_o)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [63:0] data;
        logic [1:0]  pid;
    } ent_t;

    // Reference model state (owned by the monitor)
    ent_t        mq0[$];
    ent_t        mq1[$];
    int          m_next;
    logic        m_err;
    logic        acc0, acc1;
    logic [63:0] rf_dut [32];

    // Golden register file built from program order (owned by the stimulus)
    logic [63:0] rf_gold [32];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs with the model, then retire and accept like the spec says
    always @(negedge clk) begin : mon
        ent_t e0, e1;
        bit   h0, h1, old0, c0, c1, w0, w1;
        int   s0, s1;
        logic [1:0] nx, nx1;
        if (reset) begin
            mq0.delete();
            mq1.delete();
            m_next = 0;
            m_err  = 1'b0;
            acc0   = 1'b0;
            acc1   = 1'b0;
            for (int i = 0; i < 32; i++) rf_dut[i] = '0;
        end else begin
            s0 = mq0.size();
            s1 = mq1.size();
            h0 = (s0 > 0);
            h1 = (s1 > 0);
            e0 = h0 ? mq0[0] : '{we: 1'b0, addr: 5'd0, data: 64'd0, pid: 2'd0};
            e1 = h1 ? mq1[0] : '{we: 1'b0, addr: 5'd0, data: 64'd0, pid: 2'd1};

            chk("way0_ready_o", way0_ready_o, (s0 < DEPTH));
            chk("way1_ready_o", way1_ready_o, (s1 < DEPTH));
            chk("way0_rdAddr_o", way0_rdAddr_o, e0.addr);
            chk("way1_rdAddr_o", way1_rdAddr_o, e1.addr);
            chk("way0_rdData_o", way0_rdData_o, e0.data);
            chk("way1_rdData_o", way1_rdData_o, e1.data);
            chk("way0_WBU_pID_o", way0_WBU_pID_o, e0.pid);
            chk("way1_WBU_pID_o", way1_WBU_pID_o, e1.pid);
            chk("pid_err_o", pid_err_o, m_err);

            // The oldest outstanding result carries pID m_next; only it, and then its
            // immediate successor, may retire this cycle
            nx   = m_next[1:0];
            nx1  = nx + 2'd1;
            old0 = (nx[0] == 1'b0);
            if (old0) begin
                c0 = h0 && (e0.pid == nx) && way0_ready_i;
                c1 = c0 && h1 && (e1.pid == nx1) && way1_ready_i;
            end else begin
                c1 = h1 && (e1.pid == nx) && way1_ready_i;
                c0 = c1 && h0 && (e0.pid == nx1) && way0_ready_i;
            end
            w0 = c0 && e0.we && (e0.addr != 5'd0);
            w1 = c1 && e1.we && (e1.addr != 5'd0);
            if (w0 && w1 && (e0.addr == e1.addr)) begin
                if (old0) w0 = 1'b0;
                else      w1 = 1'b0;
            end
            chk("way0_rdWriteEnable_o", way0_rdWriteEnable_o, w0);
            chk("way1_rdWriteEnable_o", way1_rdWriteEnable_o, w1);

            // Regfile view of what the DUT actually wrote, older port first
            if (old0) begin
                if (way0_rdWriteEnable_o) rf_dut[way0_rdAddr_o] = way0_rdData_o;
                if (way1_rdWriteEnable_o) rf_dut[way1_rdAddr_o] = way1_rdData_o;
            end else begin
                if (way1_rdWriteEnable_o) rf_dut[way1_rdAddr_o] = way1_rdData_o;
                if (way0_rdWriteEnable_o) rf_dut[way0_rdAddr_o] = way0_rdData_o;
            end

            m_next = (m_next + int'(c0) + int'(c1)) % 4;
            if (c0) void'(mq0.pop_front());
            if (c1) void'(mq1.pop_front());

            acc0 = way0_valid_i && (s0 < DEPTH);
            acc1 = way1_valid_i && (s1 < DEPTH);
            if (acc0) begin
                if (!way0_pID_i[0])
                    mq0.push_back('{we: way0_rdWriteEnable_i, addr: way0_rdAddr_i,
                                    data: way0_rdData_i, pid: way0_pID_i});
                else
                    m_err = 1'b1;
            end
            if (acc1) begin
                if (way1_pID_i[0])
                    mq1.push_back('{we: way1_rdWriteEnable_i, addr: way1_rdAddr_i,
                                    data: way1_rdData_i, pid: way1_pID_i});
                else
                    m_err = 1'b1;
            end
        end
    end

    task automatic set0(input logic v, input logic we, input logic [4:0] a,
                        input logic [63:0] d, input logic [1:0] p);
        way0_valid_i = v; way0_rdWriteEnable_i = we; way0_rdAddr_i = a;
        way0_rdData_i = d; way0_pID_i = p;
    endtask

    task automatic set1(input logic v, input logic we, input logic [4:0] a,
                        input logic [63:0] d, input logic [1:0] p);
        way1_valid_i = v; way1_rdWriteEnable_i = we; way1_rdAddr_i = a;
        way1_rdData_i = d; way1_pID_i = p;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we0"},   way0_rdWriteEnable_o, 1'b0);
        chk({tag, "_we1"},   way1_rdWriteEnable_o, 1'b0);
        chk({tag, "_addr0"}, way0_rdAddr_o, 5'd0);
        chk({tag, "_addr1"}, way1_rdAddr_o, 5'd0);
        chk({tag, "_data0"}, way0_rdData_o, 64'd0);
        chk({tag, "_data1"}, way1_rdData_o, 64'd0);
        chk({tag, "_pid0"},  way0_WBU_pID_o, 2'b00);
        chk({tag, "_pid1"},  way1_WBU_pID_o, 2'b01);
        chk({tag, "_rdy0"},  way0_ready_o, 1'b1);
        chk({tag, "_rdy1"},  way1_ready_o, 1'b1);
        chk({tag, "_err"},   pid_err_o, 1'b0);
    endtask

    ent_t s0q[$];
    ent_t s1q[$];
    int   pres0, pres1, cyc, r;
    ent_t ne;

    initial begin
        reset = 1'b1;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 1);
        way0_ready_i = 1'b1;
        way1_ready_i = 1'b1;
        step(2);
        check_reset_outputs("reset");
        @(posedge clk);
        #2 reset = 1'b0;
        step(1);

        // In-order dual commit
        set0(1, 1, 5'd5, 64'hA, 2'd0); set1(1, 1, 5'd6, 64'hB, 2'd1);
        step(1);
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 1);
        step(2);

        // Same destination in one dual commit; pID wraps to 00 afterwards
        set0(1, 1, 5'd7, 64'h1, 2'd2); set1(1, 1, 5'd7, 64'h2, 2'd3);
        step(1);
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 1);
        step(2);

        // Way1 arrives well before way0
        set1(1, 1, 5'd8, 64'hC, 2'd1);
        step(1);
        set1(0, 0, 0, 0, 1);
        step(2);
        set0(1, 1, 5'd9, 64'hD, 2'd0);
        step(1);
        set0(0, 0, 0, 0, 0);
        step(2);

        // x0 destination and a no-write result still consume their slots
        set0(1, 1, 5'd0, 64'hE, 2'd2); set1(1, 0, 5'd10, 64'hF, 2'd3);
        step(1);
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 1);
        step(2);

        // Wrong-parity pID on way0 is dropped and flagged
        set0(1, 1, 5'd11, 64'h5, 2'd1);
        step(1);
        set0(0, 0, 0, 0, 0);
        step(2);

        // Backpressure on port 0 until way0 fills, then release
        way0_ready_i = 1'b0;
        set0(1, 1, 5'd12, 64'h10, 2'd0); set1(1, 1, 5'd13, 64'h11, 2'd1);
        step(1);
        set0(1, 1, 5'd14, 64'h12, 2'd2); set1(1, 1, 5'd15, 64'h13, 2'd3);
        step(1);
        set0(1, 1, 5'd16, 64'h14, 2'd0); set1(0, 0, 0, 0, 1);
        step(3);
        set0(0, 0, 0, 0, 0);
        way0_ready_i = 1'b1;
        step(4);

        // Reset with three results buffered
        way0_ready_i = 1'b0; way1_ready_i = 1'b0;
        set0(1, 1, 5'd17, 64'h20, 2'd0); set1(1, 1, 5'd18, 64'h21, 2'd1);
        step(1);
        set0(1, 1, 5'd19, 64'h22, 2'd2); set1(0, 0, 0, 0, 1);
        step(1);
        set0(0, 0, 0, 0, 0);
        step(1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("midreset");
        @(posedge clk);
        #2 reset = 1'b0;
        way0_ready_i = 1'b1; way1_ready_i = 1'b1;
        step(3);

        // Random program: instruction k has pID k%4 and issues on way k%2
        for (int i = 0; i < 32; i++) rf_gold[i] = '0;
        for (int k = 0; k < NPROG; k++) begin
            ne.pid  = 2'(k % 4);
            ne.we   = ($urandom_range(0, 3) != 0);
            ne.addr = 5'($urandom_range(0, 31));
            ne.data = {$urandom, $urandom};
            if (ne.we && ne.addr != 5'd0) rf_gold[ne.addr] = ne.data;
            if (k % 2 == 0) s0q.push_back(ne);
            else            s1q.push_back(ne);
        end
        pres0 = 0; pres1 = 0; cyc = 0;
        while ((s0q.size() > 0 || s1q.size() > 0 || pres0 == 1 || pres1 == 1) && cyc < MAXCYC) begin
            if (pres0 == 1 && acc0) begin void'(s0q.pop_front()); pres0 = 0; end
            if (pres1 == 1 && acc1) begin void'(s1q.pop_front()); pres1 = 0; end
            if (pres0 == 2) pres0 = 0;
            if (pres1 == 2) pres1 = 0;
            if (pres0 == 0) begin
                r = $urandom_range(0, 99);
                if (r < 55 && s0q.size() > 0) begin
                    set0(1, s0q[0].we, s0q[0].addr, s0q[0].data, s0q[0].pid);
                    pres0 = 1;
                end else if (r < 59) begin
                    set0(1, 1, 5'($urandom_range(1, 31)), {$urandom, $urandom},
                         {1'($urandom_range(0, 1)), 1'b1});
                    pres0 = 2;
                end else begin
                    set0(0, 0, 0, 0, 0);
                end
            end
            if (pres1 == 0) begin
                r = $urandom_range(0, 99);
                if (r < 55 && s1q.size() > 0) begin
                    set1(1, s1q[0].we, s1q[0].addr, s1q[0].data, s1q[0].pid);
                    pres1 = 1;
                end else if (r < 59) begin
                    set1(1, 1, 5'($urandom_range(1, 31)), {$urandom, $urandom},
                         {1'($urandom_range(0, 1)), 1'b0});
                    pres1 = 2;
                end else begin
                    set1(0, 0, 0, 0, 1);
                end
            end
            way0_ready_i = ($urandom_range(0, 3) != 0);
            way1_ready_i = ($urandom_range(0, 3) != 0);
            step(1);
            cyc++;
        end
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 1);
        way0_ready_i = 1'b1; way1_ready_i = 1'b1;
        step(2 * DEPTH + 4);

        chk("random_issue_within_budget", (cyc < MAXCYC), 1'b1);
        chk("model_drained", mq0.size() + mq1.size(), 0);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("regfile_x%0d", i), rf_dut[i], rf_gold[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_wbu_commit_arbiter
`default_nettype wire
